// File: rtl/fsmc_mailbox_pkg.sv
// Shared constants for the FSMC mailbox: register addresses, status bit
// positions, flush bit positions and the packed status word layout.
package fsmc_mailbox_pkg;

    localparam int MBOX_ADR_DATA    = 0;
    localparam int MBOX_ADR_STATUS  = 1;
    localparam int MBOX_ADR_H2F_LVL = 2;
    localparam int MBOX_ADR_F2H_LVL = 3;

    localparam int ST_H2F_FULL  = 0;
    localparam int ST_H2F_EMPTY = 1;
    localparam int ST_F2H_FULL  = 2;
    localparam int ST_F2H_EMPTY = 3;
    localparam int ST_H2F_OVF   = 4;
    localparam int ST_F2H_UNF   = 5;

    localparam int FL_H2F = 0;
    localparam int FL_F2H = 1;

    // Last member lands on bit 0, so the field order mirrors the bit indices above.
    typedef struct packed {
        logic f2h_unf;
        logic h2f_ovf;
        logic f2h_empty;
        logic f2h_full;
        logic h2f_empty;
        logic h2f_full;
    } mbox_status_t;

endpackage

// File: rtl/fsmc_mailbox_if.sv
// Bus-side strobes plus the two fabric streams of the mailbox, grouped so the
// bus slave and fabric see one bundle. slave = mailbox side, master = driver side.
interface fsmc_mailbox_if #(
    parameter int ADRW = 2,
    parameter int DATW = 8
);
    logic [ADRW-1:0] rw_adr;
    logic            do_write;
    logic [DATW-1:0] w_data;
    logic            do_read;
    logic [DATW-1:0] read_data;

    logic            h2f_valid;
    logic [DATW-1:0] h2f_data;
    logic            h2f_ready;

    logic            f2h_valid;
    logic [DATW-1:0] f2h_data;
    logic            f2h_ready;

    logic            irq;

    modport slave (
        input  rw_adr, do_write, w_data, do_read, h2f_ready, f2h_valid, f2h_data,
        output read_data, h2f_valid, h2f_data, f2h_ready, irq
    );

    modport master (
        output rw_adr, do_write, w_data, do_read, h2f_ready, f2h_valid, f2h_data,
        input  read_data, h2f_valid, h2f_data, f2h_ready, irq
    );
endinterface

// File: rtl/fsmc_mailbox_fifo.sv
// Distributed-memory FIFO with show-ahead head, flush and fill level. Pointers
// carry one extra wrap bit so full and empty are told apart without a counter.
module mbox_fifo #(
    parameter int DATW  = 8,
    parameter int DEPTH = 16,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_flush,
    input  logic [DATW-1:0] i_wdata,
    output logic [DATW-1:0] o_head,
    output logic            o_full,
    output logic            o_empty,
    output logic [LW-1:0]   o_level
);

    logic [DATW-1:0] r_mem [DEPTH];
    logic [LW-1:0]   r_wr_ptr;
    logic [LW-1:0]   r_rd_ptr;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[LW-1] != r_rd_ptr[LW-1]) &&
                     (r_wr_ptr[LW-2:0] == r_rd_ptr[LW-2:0]);

    // A pop on an empty FIFO does nothing, so a push there never falls through.
    // A push on a full FIFO is only taken when a pop frees the slot this cycle.
    assign w_pop  = i_pop & ~w_empty;
    assign w_push = i_push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr[LW-2:0]] <= i_wdata;
        end
    end

    assign o_head  = r_mem[r_rd_ptr[LW-2:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/fsmc_mailbox.sv
// Register-mapped mailbox behind the FSMC bus slave: h2f and f2h FIFOs, status,
// levels and sticky error flags. Define FSMC_MBOX_IRQ_EN for a registered irq.
module fsmc_mailbox
    import fsmc_mailbox_pkg::*;
#(
    parameter int ADRW  = 2,
    parameter int DATW  = 8,
    parameter int DEPTH = 16,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               nrst,
    fsmc_mailbox_if.slave      bus
);

    logic            w_rd;
    logic            w_wr;
    logic            w_sel_data;
    logic            w_sel_status;
    logic            w_sel_h2f_lvl;
    logic            w_sel_f2h_lvl;

    logic [DATW-1:0] w_h2f_head;
    logic            w_h2f_full;
    logic            w_h2f_empty;
    logic [LW-1:0]   w_h2f_level;
    logic            w_h2f_push;
    logic            w_h2f_pop;
    logic            w_h2f_flush;

    logic [DATW-1:0] w_f2h_head;
    logic            w_f2h_full;
    logic            w_f2h_empty;
    logic [LW-1:0]   w_f2h_level;
    logic            w_f2h_push;
    logic            w_f2h_pop;
    logic            w_f2h_flush;

    logic            w_ovf_set;
    logic            w_ovf_clr;
    logic            w_unf_set;
    logic            w_unf_clr;
    logic            r_h2f_ovf;
    logic            r_f2h_unf;

    mbox_status_t    w_status;
    logic [DATW-1:0] w_read_data;

    // Read has priority: a write strobe coincident with a read is dropped.
    assign w_rd = bus.do_read;
    assign w_wr = bus.do_write & ~bus.do_read;

    assign w_sel_data    = (bus.rw_adr == ADRW'(MBOX_ADR_DATA));
    assign w_sel_status  = (bus.rw_adr == ADRW'(MBOX_ADR_STATUS));
    assign w_sel_h2f_lvl = (bus.rw_adr == ADRW'(MBOX_ADR_H2F_LVL));
    assign w_sel_f2h_lvl = (bus.rw_adr == ADRW'(MBOX_ADR_F2H_LVL));

    assign w_h2f_flush = w_wr & w_sel_f2h_lvl & bus.w_data[FL_H2F];
    assign w_f2h_flush = w_wr & w_sel_f2h_lvl & bus.w_data[FL_F2H];

    assign w_h2f_push = w_wr & w_sel_data;
    assign w_h2f_pop  = ~w_h2f_empty & bus.h2f_ready;

    // f2h_ready is simply !full, so the producer never relies on a pop bypass.
    assign w_f2h_push = bus.f2h_valid & ~w_f2h_full;
    assign w_f2h_pop  = w_rd & w_sel_data & ~w_f2h_empty;

    mbox_fifo #(
        .DATW  (DATW),
        .DEPTH (DEPTH)
    ) u_h2f (
        .clk     (clk),
        .nrst    (nrst),
        .i_push  (w_h2f_push),
        .i_pop   (w_h2f_pop),
        .i_flush (w_h2f_flush),
        .i_wdata (bus.w_data),
        .o_head  (w_h2f_head),
        .o_full  (w_h2f_full),
        .o_empty (w_h2f_empty),
        .o_level (w_h2f_level)
    );

    mbox_fifo #(
        .DATW  (DATW),
        .DEPTH (DEPTH)
    ) u_f2h (
        .clk     (clk),
        .nrst    (nrst),
        .i_push  (w_f2h_push),
        .i_pop   (w_f2h_pop),
        .i_flush (w_f2h_flush),
        .i_wdata (bus.f2h_data),
        .o_head  (w_f2h_head),
        .o_full  (w_f2h_full),
        .o_empty (w_f2h_empty),
        .o_level (w_f2h_level)
    );

    // A flushed FIFO loses the push without flagging overflow.
    assign w_ovf_set = w_h2f_push & w_h2f_full & ~w_h2f_pop & ~w_h2f_flush;
    assign w_unf_set = w_rd & w_sel_data & w_f2h_empty;
    assign w_ovf_clr = w_wr & w_sel_status & bus.w_data[ST_H2F_OVF];
    assign w_unf_clr = w_wr & w_sel_status & bus.w_data[ST_F2H_UNF];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_h2f_ovf <= 1'b0;
            r_f2h_unf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_h2f_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_h2f_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_f2h_unf <= 1'b1;
            end else if (w_unf_clr) begin
                r_f2h_unf <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status           = '0;
        w_status.h2f_full  = w_h2f_full;
        w_status.h2f_empty = w_h2f_empty;
        w_status.f2h_full  = w_f2h_full;
        w_status.f2h_empty = w_f2h_empty;
        w_status.h2f_ovf   = r_h2f_ovf;
        w_status.f2h_unf   = r_f2h_unf;
    end

    // The bus slave latches this on the do_read edge, the same edge that pops.
    always_comb begin
        w_read_data = '0;
        if (w_sel_data) begin
            w_read_data = w_f2h_empty ? '0 : w_f2h_head;
        end else if (w_sel_status) begin
            w_read_data = DATW'(w_status);
        end else if (w_sel_h2f_lvl) begin
            w_read_data = DATW'(w_h2f_level);
        end else if (w_sel_f2h_lvl) begin
            w_read_data = DATW'(w_f2h_level);
        end
    end

    assign bus.read_data = w_read_data;
    assign bus.h2f_valid = ~w_h2f_empty;
    assign bus.h2f_data  = w_h2f_head;
    assign bus.f2h_ready = ~w_f2h_full;

`ifdef FSMC_MBOX_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= ~w_f2h_empty | r_h2f_ovf | r_f2h_unf;
        end
    end

    assign bus.irq = r_irq;
`else
    assign bus.irq = 1'b0;
`endif

endmodule
